// File: rtl/regfile_master.sv
// regfile_master: multi-cycle initiator for the processor register-file port.
// Accepts one read or write request at a time, sequences setup / pc-step /
// capture on the rf_* lines, returns read data over a valid/ready channel and
// keeps saturating access counters for bring-up.
module regfile_master #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS),
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [IDX_W-1:0]  req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [IDX_W-1:0]  req_raddr1,
  input  logic [IDX_W-1:0]  req_raddr2,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  // register-file port
  output logic [2:0]        rf_pc,
  output logic              rf_mem_w,
  output logic              rf_mem_r,
  output logic              rf_alu_op,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [IDX_W-1:0]  rf_raddr1,
  output logic [IDX_W-1:0]  rf_raddr2,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  // status
  output logic [STAT_W-1:0] wr_count,
  output logic [STAT_W-1:0] rd_count,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StResp} state_e;

  localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};

  state_e state_q;
  logic   op_write_q;
  logic   wr_idx_ok;
  logic   rd_idx_ok;

  // Range-check incoming indices; the attached file may hold fewer than 2**IDX_W registers.
  always_comb begin
    wr_idx_ok = 32'(req_waddr) < NUM_REGS;
    rd_idx_ok = (32'(req_raddr1) < NUM_REGS) && (32'(req_raddr2) < NUM_REGS);
  end

  // Sequencer: every output is a register updated alongside the state. The rf_* address/data
  // lines double as the latched request, so they are loaded at acceptance and visible in SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data1  <= '0;
      rsp_data2  <= '0;
      rsp_err    <= 1'b0;
      rf_pc      <= '0;
      rf_mem_w   <= 1'b0;
      rf_mem_r   <= 1'b0;
      rf_alu_op  <= 1'b0;
      rf_waddr   <= '0;
      rf_raddr1  <= '0;
      rf_raddr2  <= '0;
      rf_wdata   <= '0;
      wr_count   <= '0;
      rd_count   <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          // req_ready is still 0 in the first cycle after reset, so nothing is taken then.
          if (req_valid && req_ready) begin
            if (req_write) begin
              // Out-of-range write is swallowed: no trigger, no count, stay ready.
              if (wr_idx_ok) begin
                op_write_q <= 1'b1;
                rf_waddr   <= req_waddr;
                rf_wdata   <= req_wdata;
                rf_raddr1  <= req_raddr1;
                rf_raddr2  <= req_raddr2;
                rf_mem_w   <= 1'b1;
                rf_alu_op  <= 1'b1;
                rf_mem_r   <= 1'b0;
                req_ready  <= 1'b0;
                busy       <= 1'b1;
                state_q    <= StSetup;
              end
            end else if (rd_idx_ok) begin
              op_write_q <= 1'b0;
              rf_waddr   <= req_waddr;
              rf_wdata   <= req_wdata;
              rf_raddr1  <= req_raddr1;
              rf_raddr2  <= req_raddr2;
              rf_mem_r   <= 1'b1;
              rf_alu_op  <= 1'b0;
              rf_mem_w   <= 1'b0;
              req_ready  <= 1'b0;
              busy       <= 1'b1;
              state_q    <= StSetup;
            end else begin
              // Out-of-range read: answer straight away with an error and zero data.
              op_write_q <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_data1  <= '0;
              rsp_data2  <= '0;
              req_ready  <= 1'b0;
              busy       <= 1'b1;
              state_q    <= StResp;
            end
          end
        end

        StSetup: begin
          // Mode lines are already up, so the step below always fires a real access.
          rf_pc   <= rf_pc + 3'd1;
          state_q <= StStrobe;
        end

        StStrobe: begin
          rf_mem_w  <= 1'b0;
          rf_mem_r  <= 1'b0;
          rf_alu_op <= 1'b0;
          if (op_write_q) begin
            if (wr_count != StatMax) begin
              wr_count <= wr_count + STAT_W'(1);
            end
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            rsp_data1 <= rf_rdata1;
            rsp_data2 <= rf_rdata2;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end
        end

        StResp: begin
          // rsp_valid is always high here; data and err are held until the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rd_count != StatMax) begin
              rd_count <= rd_count + STAT_W'(1);
            end
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// Randomized self-checking bench for regfile_master with a 12-entry register file, so that
// indices 12..15 exercise the out-of-range path. A simple register-file model is attached
// to the rf_* port; expected results come from a separate array-based reference.
module tb_regfile_master;
  localparam int unsigned NUM_REGS = 12;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STAT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [IDX_W-1:0]  req_waddr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [IDX_W-1:0]  req_raddr1 = '0;
  logic [IDX_W-1:0]  req_raddr2 = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  logic              rsp_err;
  logic [2:0]        rf_pc;
  logic              rf_mem_w;
  logic              rf_mem_r;
  logic              rf_alu_op;
  logic [IDX_W-1:0]  rf_waddr;
  logic [IDX_W-1:0]  rf_raddr1;
  logic [IDX_W-1:0]  rf_raddr2;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [STAT_W-1:0] wr_count;
  logic [STAT_W-1:0] rd_count;
  logic              busy;

  always #5 clk = ~clk;

  regfile_master #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .DATA_W   (DATA_W),
    .STAT_W   (STAT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_waddr  (req_waddr),
    .req_wdata  (req_wdata),
    .req_raddr1 (req_raddr1),
    .req_raddr2 (req_raddr2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data1  (rsp_data1),
    .rsp_data2  (rsp_data2),
    .rsp_err    (rsp_err),
    .rf_pc      (rf_pc),
    .rf_mem_w   (rf_mem_w),
    .rf_mem_r   (rf_mem_r),
    .rf_alu_op  (rf_alu_op),
    .rf_waddr   (rf_waddr),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_wdata   (rf_wdata),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wr_count   (wr_count),
    .rd_count   (rd_count),
    .busy       (busy)
  );

  // Attached register file: an access fires when rf_pc has changed; writes need rf_mem_w.
  logic [DATA_W-1:0] rf_mem [16];
  logic [2:0]        pc_seen = 3'd0;

  initial for (int i = 0; i < 16; i++) rf_mem[i] = '0;

  always @(posedge clk) begin
    if (rf_pc != pc_seen && rf_mem_w && rf_waddr < NUM_REGS) rf_mem[rf_waddr] <= rf_wdata;
    pc_seen <= rf_pc;
  end

  assign rf_rdata1 = (rf_raddr1 < NUM_REGS) ? rf_mem[rf_raddr1] : '0;
  assign rf_rdata2 = (rf_raddr2 < NUM_REGS) ? rf_mem[rf_raddr2] : '0;

  // Reference state derived from the block's rules.
  logic [DATA_W-1:0] ref_regs [16];
  int unsigned exp_pc = 0;
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag, input logic ready_exp);
    check_eq({tag, "_rf"}, {rf_pc, rf_mem_w, rf_mem_r, rf_alu_op, rf_waddr, rf_raddr1,
                            rf_raddr2, rf_wdata}, 32'd0);
    check_eq({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_data1, rsp_data2}, 32'd0);
    check_eq({tag, "_cnt"}, {wr_count, rd_count}, 32'd0);
    check_eq({tag, "_flags"}, {busy, req_ready}, {1'b0, ready_exp});
  endtask

  task automatic do_write(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d);
    logic inr;
    inr        = a < NUM_REGS;
    rsp_ready  = 1'($urandom_range(0, 1));  // must be ignored with no response pending
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_waddr  = a;
    req_wdata  = d;
    req_raddr1 = 4'($urandom);
    req_raddr2 = 4'($urandom);
    tick();
    req_valid = 1'b0;
    if (inr) begin
      check_eq("wr_setup_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b101);
      check_eq("wr_setup_pc", rf_pc, exp_pc);
      check_eq("wr_setup_ready", {req_ready, busy}, 2'b01);
      tick();
      exp_pc = (exp_pc + 1) % 8;
      check_eq("wr_strobe_pc", rf_pc, exp_pc);
      check_eq("wr_strobe_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b101);
      check_eq("wr_strobe_addr", {rf_waddr, rf_wdata}, {a, d});
      tick();
      ref_regs[a] = d;
      if (exp_wr < 65535) exp_wr++;
      check_eq("wr_done_ready", {req_ready, busy}, 2'b10);
      check_eq("wr_done_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b000);
    end else begin
      check_eq("wr_oor_ready", {req_ready, busy}, 2'b10);
      check_eq("wr_oor_pc", rf_pc, exp_pc);
      check_eq("wr_oor_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b000);
    end
    check_eq("wr_count", wr_count, exp_wr);
    check_eq("wr_no_rsp", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] a1, input logic [IDX_W-1:0] a2,
                         input int stall);
    logic inr;
    logic [DATA_W-1:0] e1, e2;
    inr        = (a1 < NUM_REGS) && (a2 < NUM_REGS);
    e1         = inr ? ref_regs[a1] : '0;
    e2         = inr ? ref_regs[a2] : '0;
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_raddr1 = a1;
    req_raddr2 = a2;
    req_waddr  = 4'($urandom);
    req_wdata  = 8'($urandom);
    tick();
    req_valid = 1'b0;
    if (!inr) begin
      check_eq("rd_oor_pc", rf_pc, exp_pc);
      check_eq("rd_oor_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b000);
    end else begin
      check_eq("rd_setup_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b010);
      check_eq("rd_setup_rsp", rsp_valid, 1'b0);
      tick();
      exp_pc = (exp_pc + 1) % 8;
      check_eq("rd_strobe_pc", rf_pc, exp_pc);
      check_eq("rd_strobe_addr", {rf_raddr1, rf_raddr2}, {a1, a2});
      tick();
      check_eq("rd_resp_mode", {rf_mem_w, rf_mem_r, rf_alu_op}, 3'b000);
    end
    check_eq("rd_valid", rsp_valid, 1'b1);
    check_eq("rd_data", {rsp_err, rsp_data1, rsp_data2}, {~inr, e1, e2});
    check_eq("rd_ready_low", {req_ready, busy}, 2'b01);
    for (int s = 0; s < stall; s++) begin
      // A request arriving while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'b1;
      req_waddr = 4'($urandom_range(0, 11));
      tick();
      check_eq("stall_held", {rsp_valid, rsp_err, rsp_data1, rsp_data2}, {1'b1, ~inr, e1, e2});
      check_eq("stall_ready", req_ready, 1'b0);
      check_eq("stall_pc", rf_pc, exp_pc);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (exp_rd < 65535) exp_rd++;
    check_eq("rd_done", {rsp_valid, req_ready, busy}, 3'b010);
    check_eq("rd_count", rd_count, exp_rd);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_cleared(tag, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    exp_pc = 0;
    exp_wr = 0;
    exp_rd = 0;
    check_eq({tag, "_ready"}, {req_ready, busy}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] old7, new7;
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset", 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check_eq("reset_ready", {req_ready, busy}, 2'b10);

    // Directed sequence
    do_write(4'd3, 8'hA5);
    do_write(4'd5, 8'h3C);
    do_read(4'd5, 4'd3, 0);
    do_read(4'd3, 4'd5, 5);
    do_read(4'd13, 4'd2, 0);
    do_write(4'd13, 8'h55);
    do_read(4'd2, 4'd15, 2);

    // Nine back-to-back writes from pc = 0: the eighth wraps pc 7 -> 0
    pulse_reset("rst_b2b");
    for (int i = 0; i < 9; i++) do_write(4'(i), 8'(8'h10 + i * 8'h11));
    check_eq("b2b_wr_count", wr_count, 32'd9);
    check_eq("b2b_pc", rf_pc, 32'd1);
    for (int i = 0; i < 10; i += 2) do_read(4'(i), 4'(i + 1), 0);

    // Reset during STROBE of a write to reg 7
    old7       = ref_regs[7];
    new7       = old7 ^ 8'hFF;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_waddr  = 4'd7;
    req_wdata  = new7;
    tick();
    req_valid = 1'b0;
    tick();
    check_eq("mid_strobe_mode", {rf_mem_w, rf_alu_op}, 2'b11);
    #2;
    pulse_reset("rst_mid");
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_raddr1 = 4'd7;
    req_raddr2 = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_rd7_valid", rsp_valid, 1'b1);
    check_eq("rst_rd7_intact", {31'd0, (rsp_data1 == old7 || rsp_data1 == new7)}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_pc = 1;
    exp_rd = 1;
    check_eq("rst_rd7_count", rd_count, 32'd1);
    do_write(4'd7, 8'h77);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("idle_no_rsp", {rsp_valid, req_ready, busy}, 3'b010);
        check_eq("idle_rd_count", rd_count, exp_rd);
      end
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom_range(0, 15)), 8'($urandom));
      else
        do_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_master.md
# regfile_master

Multi-cycle initiator that drives the processor's register-file port on behalf of a client (the decode/execute stage or a debug port). It takes one read or write request at a time over a valid/ready handshake and builds the register-file control sequence: address/data/mode setup, then a `pc` step to trigger the access, then read-data capture. Read results are returned over a valid/ready response channel. The block also keeps saturating access counters for bring-up.

## Interface
- `NUM_REGS`, 16: number of registers in the attached register file.
- `IDX_W`, `$clog2(NUM_REGS)`: register index width.
- `DATA_W`, 8: register data width.
- `STAT_W`, 16: width of the access counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_waddr` in IDX_W: write index.
- `req_wdata` in DATA_W: write data.
- `req_raddr1`, `req_raddr2` in IDX_W: read indices.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: client takes the response.
- `rsp_data1`, `rsp_data2` out DATA_W: read results.
- `rsp_err` out 1: the response is for an out-of-range index.
- `rf_pc` out 3: access trigger; each change fires one register-file access.
- `rf_mem_w`, `rf_mem_r`, `rf_alu_op` out 1: register-file mode lines.
- `rf_waddr`, `rf_raddr1`, `rf_raddr2` out IDX_W; `rf_wdata` out DATA_W.
- `rf_rdata1`, `rf_rdata2` in DATA_W: register-file read data.
- `wr_count`, `rd_count` out STAT_W: completed writes and reads, saturating.
- `busy` out 1: state is not IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - all `rf_*` outputs are 0, including `rf_pc` = 0.
  - `rsp_*` outputs are 0.
  - both counters are 0.
  - `busy` = 0.
  - `req_ready` = 1 once `rst_n` deasserts.
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request is latched and the FSM moves to SETUP.
- SETUP:
  - Address and data outputs are driven from the latched request.
  - A write sets `rf_mem_w` = 1, `rf_alu_op` = 1, `rf_mem_r` = 0.
  - A read sets `rf_mem_r` = 1, `rf_alu_op` = 0, `rf_mem_w` = 0.
  - `rf_pc` is held. The FSM moves to STROBE.
- STROBE:
  - `rf_pc` = previous + 1, modulo 8; wrap from 7 to 0 is legal.
  - Mode, address and data lines are held unchanged.
  - On a read, `rf_rdata1/2` are captured at the end of this cycle.
  - Next state is RESP for a read, IDLE for a write.
- Leaving STROBE:
  - `rf_mem_w`, `rf_mem_r` and `rf_alu_op` return to 0.
  - `rf_pc` is never stepped while the mode lines are 0.
- RESP:
  - `rsp_valid` = 1, with data and `rsp_err` held stable until `rsp_ready`.
  - When `rsp_valid && rsp_ready`, the next state is IDLE.
- Out-of-range index (any index ≥ `NUM_REGS`):
  - No trigger: `rf_pc` is not stepped and the mode lines stay 0.
  - A write completes silently and is not counted.
  - A read goes directly to RESP with data = 0 and `rsp_err` = 1, and is counted.
- Counters:
  - `wr_count` increments on leaving STROBE for a write.
  - `rd_count` increments on the RESP handshake.
  - Both saturate at 2^STAT_W − 1.
- `req_ready` is 0 in every state except IDLE. There is no request buffering.

## Timing
- Request accepted at cycle 0.
- SETUP is visible at cycle 1.
- The `rf_pc` step is visible at cycle 2.
- Write:
  - `req_ready` is high again at cycle 3.
  - Back-to-back write throughput is 1 per 3 cycles.
- Read:
  - `rsp_valid` rises at cycle 3.
  - With `rsp_ready` held high, `req_ready` returns at cycle 4.
- Out-of-range read: `rsp_valid` at cycle 1.
- `rsp_ready` low stalls in RESP indefinitely; data is not overwritten.
- `rsp_ready` while not `rsp_valid` is ignored.
- `req_valid` outside IDLE is ignored. The client must hold its request until `req_ready`.
- Reset mid-transaction:
  - All outputs clear immediately.
  - The FSM goes to IDLE and any pending response is discarded.
  - Mode lines clear in the same instant that `rf_pc` goes to 0, so no write is performed.

## Test plan
- Reset, then write reg 3 = 0xA5:
  - `rf_mem_w` = 1 and `rf_alu_op` = 1 during cycles 1–2.
  - `rf_pc` goes 0→1 at cycle 2.
  - `wr_count` = 1, `req_ready` = 1 at cycle 3.
- Write reg 5 = 0x3C, then read 5 and 3:
  - `rsp_data1` = 0x3C, `rsp_data2` = 0xA5, `rsp_err` = 0.
  - `rd_count` = 1.
- Read with `rsp_ready` low for 5 cycles:
  - `rsp_valid` is held, data stable, `req_ready` = 0.
  - Completes the cycle after `rsp_ready` rises.
- Nine back-to-back writes:
  - `rf_pc` wraps 7→0 on the 8th.
  - All 9 writes land, `wr_count` = 9.
  - Throughput is exactly 3 cycles each.
- With `NUM_REGS` = 12, read index 13:
  - `rf_pc` is unchanged.
  - `rsp_err` = 1, data = 0, `rsp_valid` at cycle 1.
- `rst_n` pulsed during STROBE of a write to reg 7:
  - All outputs are 0 asynchronously.
  - A following read of reg 7 returns the prior value or the new value, never corrupt.
  - Counters are 0.
